ssd_scan_ctrl: RTL and testbench
================================

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 SCAN_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range 2..2^20.
REQ-002 BLINK_FRAMES, 125, scan frames per blink half-period (1 Hz blink at default SCAN_DIV); legal range 1..255.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ssd  in  20  four 5-bit character codes; [19:15] is the leftmost digit (digit 3), [4:0] is the rightmost digit (digit 0).
REQ-006 upd  in  1  one-cycle request to load ssd into the display.
REQ-007 blink_mask  in  4  bit i=1 means digit i blinks.
REQ-008 ack  out  1  one-cycle pulse: a requested ssd value is now displayed.
REQ-009 active_digit  out  4  digit enables, active-low, exactly one bit low.
REQ-010 seven_in  out  5  character code for the enabled digit, to the binary-to-segment decoder.
REQ-011 frame  out  1  one-cycle pulse at each frame boundary.

Function
REQ-012 The scan counter counts 0..SCAN_DIV-1 and wraps; tick = (count==SCAN_DIV-1).
REQ-013 Digit index idx advances 0->1->2->3->0 on tick only; frame boundary = tick with idx==3.
REQ-014 frame shall pulse high for exactly the boundary cycle.
REQ-015 A shadow register holds the displayed 20-bit value; it changes only at a frame boundary, so no tearing occurs mid-frame.
REQ-016 On upd, ssd is captured into a pending register and the pending flag is set.
REQ-017 A second upd before transfer overwrites pending; only one ack results, carrying the latest value.
REQ-018 At a frame boundary with pending set: shadow <= pending, pending flag cleared, ack high the next cycle for one cycle.
REQ-019 If upd and a frame boundary coincide: shadow <= ssd directly that cycle, pending flag left clear, ack the next cycle.
REQ-020 A frame counter counts boundaries 0..BLINK_FRAMES-1; on the boundary where it equals BLINK_FRAMES-1, it wraps to 0 and blink_phase toggles.
REQ-021 Digit code = shadow[5*idx+4 : 5*idx]; if blink_mask[idx]==1 and blink_phase==1, the code is replaced by BLANK (5'b10101).
REQ-022 active_digit = ~(4'b0001 << idx).
REQ-023 active_digit and seven_in are registered, with 1-cycle latency from the idx/shadow/phase/blink_mask state.
REQ-024 blink_mask is sampled combinationally each cycle, not latched at upd.
REQ-025 The block has no other states: free-running scan FSM IDX0..IDX3 plus pending-flag FSM IDLE/PEND.

Reset
REQ-026 The following registers reset as listed.
- scan count = 0
- idx = 0
- frame count = 0
- blink_phase = 0 (visible)
- pending flag = 0
- ack = 0
- frame = 0
REQ-027 On reset, shadow and pending = {BLANK,BLANK,BLANK,BLANK}; cycle after reset, active_digit=4'b1110 and seven_in=5'b10101.
REQ-028 Reset mid-operation discards pending data and suppresses any ack not yet issued.
REQ-029 upd asserted together with rst is ignored.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-030 Scan: release rst, hold upd=0 -> active_digit cycles 1110,1101,1011,0111 every 4 clk; frame pulses every 16 clk; seven_in=10101 throughout.
REQ-031 Load: upd with ssd={5'h0C,5'h10,5'h05,5'h11} mid-frame -> seven_in unchanged until boundary; ack one cycle after it; next frame shows 11,05,10,0C for digits 0..3.
REQ-032 Coalesce: upd ssd=A, then upd ssd=B before boundary -> single ack; display shows B and never A.
REQ-033 Coincident: upd on the boundary cycle -> shadow updated that cycle; ack the next cycle; no second ack at the following boundary.
REQ-034 Blink: blink_mask=4'b0001 -> digit 0 shows BLANK during frames 2-3, 6-7, ... (phase=1); digits 1-3 are never blanked.
REQ-035 Reset mid-pend: upd, then rst before boundary -> no ack; display BLANK; outputs match the REQ-027 values.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexed four-digit seven-segment scan controller.
// Scans the digits round-robin. Display updates are applied only at frame
// boundaries, so one scan frame never mixes old and new values. Digits can
// optionally blink.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   ssd[19:0]    four 5-bit character codes, [19:15] = digit 3 ... [4:0] = digit 0
//   upd          one-cycle request to load ssd into the display
//   blink_mask   bit i set -> digit i blinks
//   ack          one-cycle pulse once a requested value is being displayed
//   active_digit active-low digit enables, exactly one bit low
//   seven_in     character code for the enabled digit
//   frame        one-cycle pulse during each frame-boundary cycle
module ssd_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] ssd,
  input  logic        upd,
  input  logic [3:0]  blink_mask,
  output logic        ack,
  output logic [3:0]  active_digit,
  output logic [4:0]  seven_in,
  output logic        frame
);

  localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FCNT_W = 8;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_FRAMES - 1);

  localparam logic [4:0]  BLANK   = 5'b10101;
  localparam logic [19:0] BLANK_4 = {BLANK, BLANK, BLANK, BLANK};

  // scan FSM: one state per enabled digit
  localparam logic [1:0] IDX0 = 2'd0;
  localparam logic [1:0] IDX1 = 2'd1;
  localparam logic [1:0] IDX2 = 2'd2;
  localparam logic [1:0] IDX3 = 2'd3;

  // pending-update FSM
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [CNT_W-1:0]  cnt,       cnt_n;
  logic [1:0]        idx,       idx_n;
  logic [0:0]        pend,      pend_n;
  logic [FCNT_W-1:0] fcnt,      fcnt_n;
  logic              phase,     phase_n;
  logic [19:0]       shadow,    shadow_n;
  logic [19:0]       pending,   pending_n;
  logic              ack_n;
  logic              frame_n;
  logic [3:0]        active_n;
  logic [4:0]        seven_n;
  logic [4:0]        code;
  logic              tick;
  logic              boundary;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= IDX0;
      pend         <= IDLE;
      fcnt         <= '0;
      phase        <= 1'b0;
      shadow       <= BLANK_4;
      pending      <= BLANK_4;
      ack          <= 1'b0;
      frame        <= 1'b0;
      active_digit <= 4'b1110;
      seven_in     <= BLANK;
    end else begin
      cnt          <= cnt_n;
      idx          <= idx_n;
      pend         <= pend_n;
      fcnt         <= fcnt_n;
      phase        <= phase_n;
      shadow       <= shadow_n;
      pending      <= pending_n;
      ack          <= ack_n;
      frame        <= frame_n;
      active_digit <= active_n;
      seven_in     <= seven_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    cnt_n     = cnt;
    idx_n     = idx;
    pend_n    = pend;
    fcnt_n    = fcnt;
    phase_n   = phase;
    shadow_n  = shadow;
    pending_n = pending;
    ack_n     = 1'b0;
    code      = BLANK;

    tick     = (cnt == CNT_MAX);
    boundary = tick && (idx == IDX3);

    cnt_n = tick ? '0 : cnt + CNT_W'(1);

    case (idx)
      IDX0:    if (tick) idx_n = IDX1;
      IDX1:    if (tick) idx_n = IDX2;
      IDX2:    if (tick) idx_n = IDX3;
      IDX3:    if (tick) idx_n = IDX0;
      default: idx_n = IDX0;
    endcase

    // Capture requests; a later upd simply overwrites the earlier one
    if (upd) pending_n = ssd;

    case (pend)
      IDLE:    if (upd && !boundary) pend_n = PEND;
      PEND:    if (boundary) pend_n = IDLE;
      default: pend_n = IDLE;
    endcase

    // An upd that lands on the boundary bypasses the pending register
    if (boundary) begin
      if (upd) begin
        shadow_n = ssd;
        ack_n    = 1'b1;
      end else if (pend == PEND) begin
        shadow_n = pending;
        ack_n    = 1'b1;
      end
    end

    if (boundary) begin
      if (fcnt == FCNT_MAX) begin
        fcnt_n  = '0;
        phase_n = ~phase;
      end else begin
        fcnt_n = fcnt + FCNT_W'(1);
      end
    end

    // Registered frame is high while the state sits on the boundary cycle
    frame_n = (cnt_n == CNT_MAX) && (idx_n == IDX3);

    case (idx)
      IDX0:    code = shadow[4:0];
      IDX1:    code = shadow[9:5];
      IDX2:    code = shadow[14:10];
      IDX3:    code = shadow[19:15];
      default: code = BLANK;
    endcase

    seven_n  = (blink_mask[idx] && phase) ? BLANK : code;
    active_n = ~(4'b0001 << idx);
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl with SCAN_DIV=4, BLINK_FRAMES=2.
// t counts rising edges since the last reset edge; outputs are sampled on the
// falling edge and inputs change right after sampling.
module tb_ssd_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [19:0] ssd;
  logic        upd;
  logic [3:0]  blink_mask;
  logic        ack;
  logic [3:0]  active_digit;
  logic [4:0]  seven_in;
  logic        frame;

  int t;
  int vectors;
  int miscompares;

  localparam logic [19:0] SSD_L  = {5'h0C, 5'h10, 5'h05, 5'h11};
  localparam logic [19:0] SSD_A  = {5'h01, 5'h02, 5'h03, 5'h04};
  localparam logic [19:0] SSD_B  = {5'h05, 5'h06, 5'h07, 5'h08};
  localparam logic [19:0] SSD_C  = {5'h0A, 5'h0B, 5'h0D, 5'h0E};
  localparam logic [19:0] SSD_D  = {5'h1F, 5'h1E, 5'h1D, 5'h1C};
  localparam logic [4:0]  BL     = 5'h15;

  typedef struct {
    int         t;
    logic       upd;
    logic [19:0] ssd;
    logic [3:0] mask;
    logic       ack;
    logic [3:0] ad;
    logic [4:0] seg;
    logic       frame;
  } vec_t;

  vec_t tbl[32];

  ssd_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .ssd          (ssd),
    .upd          (upd),
    .blink_mask   (blink_mask),
    .ack          (ack),
    .active_digit (active_digit),
    .seven_in     (seven_in),
    .frame        (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at t=%0d", t);
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(int tt, logic u, logic [19:0] s, logic [3:0] m,
                              logic a, logic [3:0] ad, logic [4:0] sg, logic fr);
    vec_t v;
    v.t = tt; v.upd = u; v.ssd = s; v.mask = m;
    v.ack = a; v.ad = ad; v.seg = sg; v.frame = fr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  // Advance one clock; upd is a single-cycle request
  task automatic step();
    @(posedge clk);
    t = t + 1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      while (t < tbl[i].t) step();
      chk("ack",          32'(ack),          32'(tbl[i].ack));
      chk("active_digit", 32'(active_digit), 32'(tbl[i].ad));
      chk("seven_in",     32'(seven_in),     32'(tbl[i].seg));
      chk("frame",        32'(frame),        32'(tbl[i].frame));
      upd        = tbl[i].upd;
      ssd        = tbl[i].ssd;
      blink_mask = tbl[i].mask;
    end
  endtask

  int ack_cnt;
  int ack_t;
  logic a_seen;

  initial begin
    vectors = 0;
    miscompares = 0;
    t = 0;

    // Scan, load mid-frame, blink on digit 0
    tbl[0]  = mk(0,   0, 20'h0,  4'h0, 0, 4'b1110, BL,    0);
    tbl[1]  = mk(1,   0, 20'h0,  4'h0, 0, 4'b1110, BL,    0);
    tbl[2]  = mk(4,   0, 20'h0,  4'h0, 0, 4'b1110, BL,    0);
    tbl[3]  = mk(5,   0, 20'h0,  4'h0, 0, 4'b1101, BL,    0);
    tbl[4]  = mk(6,   1, SSD_L,  4'h0, 0, 4'b1101, BL,    0);
    tbl[5]  = mk(9,   0, 20'h0,  4'h0, 0, 4'b1011, BL,    0);
    tbl[6]  = mk(13,  0, 20'h0,  4'h0, 0, 4'b0111, BL,    0);
    tbl[7]  = mk(14,  0, 20'h0,  4'h0, 0, 4'b0111, BL,    0);
    tbl[8]  = mk(15,  0, 20'h0,  4'h0, 0, 4'b0111, BL,    1);
    tbl[9]  = mk(16,  0, 20'h0,  4'h0, 1, 4'b0111, BL,    0);
    tbl[10] = mk(17,  0, 20'h0,  4'h1, 0, 4'b1110, 5'h11, 0);
    tbl[11] = mk(18,  0, 20'h0,  4'h1, 0, 4'b1110, 5'h11, 0);
    tbl[12] = mk(21,  0, 20'h0,  4'h1, 0, 4'b1101, 5'h05, 0);
    tbl[13] = mk(25,  0, 20'h0,  4'h1, 0, 4'b1011, 5'h10, 0);
    tbl[14] = mk(29,  0, 20'h0,  4'h1, 0, 4'b0111, 5'h0C, 0);
    tbl[15] = mk(31,  0, 20'h0,  4'h1, 0, 4'b0111, 5'h0C, 1);
    tbl[16] = mk(32,  0, 20'h0,  4'h1, 0, 4'b0111, 5'h0C, 0);
    tbl[17] = mk(33,  0, 20'h0,  4'h1, 0, 4'b1110, BL,    0);
    tbl[18] = mk(37,  0, 20'h0,  4'h1, 0, 4'b1101, 5'h05, 0);
    tbl[19] = mk(41,  0, 20'h0,  4'h1, 0, 4'b1011, 5'h10, 0);
    tbl[20] = mk(45,  0, 20'h0,  4'h1, 0, 4'b0111, 5'h0C, 0);
    tbl[21] = mk(49,  0, 20'h0,  4'h1, 0, 4'b1110, BL,    0);
    tbl[22] = mk(63,  0, 20'h0,  4'h1, 0, 4'b0111, 5'h0C, 1);
    tbl[23] = mk(64,  0, 20'h0,  4'h1, 0, 4'b0111, 5'h0C, 0);
    tbl[24] = mk(65,  0, 20'h0,  4'h1, 0, 4'b1110, 5'h11, 0);
    // upd coincident with a frame boundary
    tbl[25] = mk(111, 1, SSD_C,  4'h0, 0, 4'b0111, 5'h05, 1);
    tbl[26] = mk(112, 0, 20'h0,  4'h0, 1, 4'b0111, 5'h05, 0);
    tbl[27] = mk(113, 0, 20'h0,  4'h0, 0, 4'b1110, 5'h0E, 0);
    tbl[28] = mk(117, 0, 20'h0,  4'h0, 0, 4'b1101, 5'h0D, 0);
    tbl[29] = mk(127, 0, 20'h0,  4'h0, 1'b0, 4'b0111, 5'h0A, 1);
    tbl[30] = mk(128, 0, 20'h0,  4'h0, 0, 4'b0111, 5'h0A, 0);
    tbl[31] = mk(129, 0, 20'h0,  4'h0, 0, 4'b1110, 5'h0E, 0);

    // Reset, with an upd that must be ignored
    rst = 1'b1;
    upd = 1'b1;
    ssd = SSD_A;
    blink_mask = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    upd = 1'b0;
    ssd = 20'h0;
    t = 0;

    run_table(0, 24);

    // Coalesce: A then B before the boundary; one ack, only B displayed
    blink_mask = 4'h0;
    ssd = SSD_A;
    upd = 1'b1;
    step();
    while (t < 69) step();
    ssd = SSD_B;
    upd = 1'b1;
    ack_cnt = 0;
    ack_t = -1;
    a_seen = 1'b0;
    while (t < 96) begin
      step();
      if (ack) begin
        ack_cnt++;
        ack_t = t;
      end
      if (seven_in >= 5'h01 && seven_in <= 5'h04) a_seen = 1'b1;
      if (t == 81) chk("coalesce_d0", 32'(seven_in), 32'(5'h08));
      if (t == 93) chk("coalesce_d3", 32'(seven_in), 32'(5'h05));
    end
    chk("coalesce_ack_count", 32'(ack_cnt), 32'd1);
    chk("coalesce_ack_time",  32'(ack_t),   32'd80);
    chk("coalesce_no_A",      32'(a_seen),  32'd0);

    run_table(25, 31);

    // Reset while an update is pending
    ssd = SSD_D;
    upd = 1'b1;
    step();
    chk("pend_ack_t130", 32'(ack), 32'd0);
    step();
    chk("pend_ack_t131", 32'(ack), 32'd0);
    rst = 1'b1;
    upd = 1'b1;
    ssd = SSD_A;
    step();
    chk("rst_ack",          32'(ack),          32'd0);
    chk("rst_active_digit", 32'(active_digit), 32'(4'b1110));
    chk("rst_seven_in",     32'(seven_in),     32'(BL));
    chk("rst_frame",        32'(frame),        32'd0);
    rst = 1'b0;
    t = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("post_rst_ack",   32'(ack),      32'd0);
      chk("post_rst_seven", 32'(seven_in), 32'(BL));
      chk("post_rst_frame", 32'(frame),    32'((t % 16) == 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
